serial_pattern_source: RTL and testbench
========================================

// Module: serial_pattern_source
// PURPOSE
//  Upstream stimulus stage for the JK-flip-flop sequence machine (machine_jk).
//  Captures a parallel bit pattern and plays it out serially on x, one bit per CLK, LSB first.
//  Supports one-shot and repeat modes, abort via stop, and a busy/done handshake.
//  Replaces hand-timed x waveforms with deterministic, clock-aligned sequences.
// PARAMETERS
//  WIDTH  16  maximum pattern length in bits
//  LEN_W  5   width of length/bit_idx; must satisfy 2**LEN_W > WIDTH
// PORTS
//  CLK      in   1      system clock, all state updates on posedge
//  RESET    in   1      asynchronous, active-high reset
//  load     in   1      start request; sampled only while idle
//  pattern  in   WIDTH  bits to send; pattern[0] goes out first
//  length   in   LEN_W  number of bits to send, 1..WIDTH
//  repeat   in   1      1 = replay pattern continuously; sampled with load
//  stop     in   1      abort current playback
//  x        out  1      serial output bit (registered), drives machine_jk x
//  busy     out  1      1 while a pattern is being played
//  done     out  1      one-cycle pulse after last bit of a one-shot run
//  bit_idx  out  LEN_W  index of bit currently on x (0 when idle)
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-run): x=0, busy=0, done=0, bit_idx=0, FSM=IDLE,
//    captured pattern/length/repeat cleared. Outputs change without waiting for CLK.
//  - FSM states: IDLE, RUN. IDLE->RUN on load & !stop & length!=0.
//    RUN->IDLE when last bit sent and repeat_q=0, or on stop. RUN->RUN otherwise.
//  - Capture: on the accepting edge, pattern, min(length,WIDTH), repeat are registered.
//    Latency 1: x=pattern[0], bit_idx=0, busy=1 in the cycle right after that edge.
//  - Each RUN edge: bit_idx+1, x = next captured bit. Bit k is held exactly one cycle.
//  - End of one-shot: edge after bit len-1 -> IDLE, x=0, busy=0, bit_idx=0, done=1 for one cycle.
//  - Repeat: after bit len-1, next cycle shows bit 0 again. No gap, no done pulse,
//    busy stays 1. Runs until stop.
//  - stop in RUN: next edge -> IDLE, x=0, busy=0, no done pulse.
//    stop in IDLE: no effect. stop & load in the same idle cycle: stop wins, nothing starts.
//  - load while busy: ignored, including in the done cycle.
//    load in the first idle cycle (done=1) is accepted.
//  - length=0: load ignored, stays IDLE, done not asserted.
//    length>WIDTH: clamped to WIDTH.
//  - Inputs other than load/stop/RESET are don't-care outside the accepting edge.
//  - Captured copy is kept separate from the shift register, so repeat reloads
//    without external help.
// STRUCTURE
//  - Shared include serial_pattern_defs.vh: FSM state encodings (S_IDLE=1'b0, S_RUN=1'b1),
//    default WIDTH/LEN_W.
//  - One sub-module: pattern_shreg (WIDTH-bit loadable right-shift register: load, shift,
//    reload-from-capture, ser_out = q[0]).
//  - Top holds the FSM, length/bit_idx counter, repeat_q, done pulse, and output registers.
// TESTING
//  1 RESET=1 5ns then 0 -> x=0, busy=0, done=0, bit_idx=0 before the first CLK edge.
//  2 load, pattern=4'b1101, length=4, repeat=0 -> x=1,0,1,1 on the next 4 cycles,
//    bit_idx=0..3, busy=1; then x=0, busy=0, done=1 for exactly one cycle.
//  3 pattern=3'b011, length=3, repeat=1, run 8 cycles -> x=1,1,0,1,1,0,1,1, no done pulse;
//    stop -> x=0, busy=0 next cycle, no done pulse.
//  4 load asserted mid-run with a different pattern -> ignored, original sequence completes;
//    load with length=0 -> no start; stop & load together in idle -> no start.
//  5 RESET pulse during bit 2 of an 8-bit run -> x/busy/bit_idx=0 asynchronously;
//    next load restarts from pattern[0].
//  6 Integration: source drives machine_jk x with pattern 1,1,1,1,0,0 repeating ->
//    machine_jk S/F sequence matches its state table cycle for cycle.

Source files
------------

// File: rtl/serial_pattern_source_pkg.sv
// Shared definitions for the serial pattern source: FSM encoding and default sizes.
package serial_pattern_source_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_LEN_W = 5;

endpackage

// File: rtl/serial_pattern_source_shreg.sv
// Loadable right-shift register with a private capture copy so repeat mode can reload itself.
module serial_pattern_source_shreg #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic             i_reload,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_d,
   output logic             o_ser
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_cap;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q   <= '0;
         r_cap <= '0;
      end else if (i_load) begin
         r_q   <= i_d;
         r_cap <= i_d;
      end else if (i_reload) begin
         r_q <= r_cap;
      end else if (i_clear) begin
         r_q <= '0;
      end else if (i_shift) begin
         r_q <= r_q >> 1;
      end
   end

   // Clearing on exit keeps the serial output low whenever the source is idle.
   assign o_ser = r_q[0];

endmodule

// File: rtl/serial_pattern_source.sv
// Plays a captured parallel pattern out serially, LSB first, with one-shot/repeat modes and stop abort.
module serial_pattern_source
   import serial_pattern_source_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             load,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] length,
   input  logic             repeat_en,
   input  logic             stop,
   output logic             x,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] bit_idx
);

   localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > WIDTH_L) ? WIDTH_L : len;
   endfunction

   state_t           r_state;
   state_t           w_next;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_idx;
   logic             r_rep;
   logic             r_done;
   logic             w_accept;
   logic             w_last;
   logic             w_load;
   logic             w_shift;
   logic             w_reload;
   logic             w_clear;
   logic             w_ser;

   assign w_accept = (r_state == S_IDLE) && load && !stop && (length != '0);
   assign w_last   = (r_idx == r_len - LEN_W'(1));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_RUN;
         S_RUN:   if (stop || (w_last && !r_rep)) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_load   = 1'b0;
      w_shift  = 1'b0;
      w_reload = 1'b0;
      w_clear  = 1'b0;
      case (r_state)
         S_IDLE: w_load = w_accept;
         S_RUN: begin
            w_shift  = !stop && !w_last;
            w_reload = !stop && w_last && r_rep;
            w_clear  = stop || (w_last && !r_rep);
         end
         default: w_clear = 1'b1;
      endcase
   end

   // Index restarts at zero on accept, wrap, and exit, so idle always reads 0.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_len  <= '0;
         r_idx  <= '0;
         r_rep  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == S_RUN) && !stop && w_last && !r_rep;
         r_idx  <= w_shift ? r_idx + LEN_W'(1) : '0;
         if (w_accept) begin
            r_len <= clamp_len(length);
            r_rep <= repeat_en;
         end
      end
   end

   serial_pattern_source_shreg #(
      .WIDTH(WIDTH)
   ) u_shreg (
      .i_clk    (CLK),
      .i_rst    (RESET),
      .i_load   (w_load),
      .i_shift  (w_shift),
      .i_reload (w_reload),
      .i_clear  (w_clear),
      .i_d      (pattern),
      .o_ser    (w_ser)
   );

   assign x       = w_ser;
   assign busy    = (r_state == S_RUN);
   assign done    = r_done;
   assign bit_idx = r_idx;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Directed and randomized bench for serial_pattern_source against a cycle-level playback model.
module tb_serial_pattern_source;

   localparam int WIDTH = 16;
   localparam int LEN_W = 5;

   logic             CLK;
   logic             RESET;
   logic             load;
   logic [WIDTH-1:0] pattern;
   logic [LEN_W-1:0] length;
   logic             repeat_en;
   logic             stop;
   logic             x;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] bit_idx;

   int checks = 0;
   int errors = 0;

   // Playback model: a run is "active" with k bits already advanced through the captured pattern.
   bit               m_active;
   logic [WIDTH-1:0] m_pat;
   int               m_len;
   bit               m_rep;
   int               m_k;
   bit               m_done;

   serial_pattern_source #(
      .WIDTH(WIDTH),
      .LEN_W(LEN_W)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .load      (load),
      .pattern   (pattern),
      .length    (length),
      .repeat_en (repeat_en),
      .stop      (stop),
      .x         (x),
      .busy      (busy),
      .done      (done),
      .bit_idx   (bit_idx)
   );

   initial begin
      CLK = 1'b0;
      #7;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0;
      m_pat    = '0;
      m_len    = 0;
      m_rep    = 0;
      m_k      = 0;
      m_done   = 0;
   endtask

   task automatic model_edge();
      if (m_active) begin
         m_done = 0;
         if (stop) begin
            m_active = 0;
         end else if (m_k == m_len - 1) begin
            if (m_rep) m_k = 0;
            else begin
               m_active = 0;
               m_done   = 1;
            end
         end else begin
            m_k++;
         end
      end else begin
         m_done = 0;
         if (load && !stop && length != 0) begin
            m_active = 1;
            m_pat    = pattern;
            m_len    = (int'(length) > WIDTH) ? WIDTH : int'(length);
            m_rep    = repeat_en;
            m_k      = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".x"},    32'(x),       m_active ? 32'(m_pat[m_k]) : 32'd0);
      chk({tag, ".busy"}, 32'(busy),    32'(m_active));
      chk({tag, ".done"}, 32'(done),    32'(m_done));
      chk({tag, ".idx"},  32'(bit_idx), m_active ? 32'(m_k) : 32'd0);
   endtask

   task automatic step(input string tag);
      @(posedge CLK);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      load      = 1'b0;
      stop      = 1'b0;
      pattern   = $urandom;
      length    = LEN_W'($urandom);
      repeat_en = 1'($urandom);
   endtask

   task automatic start(input logic [WIDTH-1:0] p, input int len, input bit rep);
      load      = 1'b1;
      stop      = 1'b0;
      pattern   = p;
      length    = LEN_W'(len);
      repeat_en = rep;
   endtask

   initial begin
      model_reset();
      RESET     = 1'b1;
      load      = 1'b0;
      stop      = 1'b0;
      pattern   = '0;
      length    = '0;
      repeat_en = 1'b0;
      #5 RESET = 1'b0;
      #1;
      // Outputs must already be clear before the first clock edge.
      check_all("reset");

      // One-shot 4'b1101: x = 1,0,1,1 then a single done pulse.
      start(16'b1101, 4, 0);
      step("os_accept");
      idle_inputs();
      for (int i = 0; i < 6; i++) step("os_run");

      // Repeat 3'b011 for 8 cycles, then stop.
      start(16'b011, 3, 1);
      step("rep_accept");
      idle_inputs();
      for (int i = 0; i < 7; i++) step("rep_run");
      stop = 1'b1;
      step("rep_stop");
      stop = 1'b0;
      step("rep_after");

      // Load mid-run with another pattern is ignored.
      start(16'hA5C3, 8, 0);
      step("ml_accept");
      for (int i = 0; i < 3; i++) begin
         load = 1'b1; pattern = 16'hFFFF; length = 5'd2; repeat_en = 1'b1;
         step("ml_ignored");
      end
      idle_inputs();
      for (int i = 0; i < 5; i++) step("ml_tail");
      // Load presented in the done cycle is accepted.
      start(16'b10, 2, 0);
      step("done_cycle_load");
      idle_inputs();
      for (int i = 0; i < 3; i++) step("dcl_run");

      // length=0 does not start; stop & load together in idle does not start.
      start(16'hFFFF, 0, 0);
      step("len0");
      idle_inputs();
      step("len0_after");
      start(16'hFFFF, 5, 0);
      stop = 1'b1;
      step("stop_load");
      idle_inputs();
      step("stop_load_after");

      // Oversized length clamps to WIDTH.
      start(16'h8001, 31, 0);
      step("clamp_accept");
      idle_inputs();
      for (int i = 0; i < 17; i++) step("clamp_run");

      // Async reset during bit 2 of an 8-bit run.
      start(16'b1111_0111, 8, 0);
      step("ar_accept");
      idle_inputs();
      step("ar_b1");
      step("ar_b2");
      #2 RESET = 1'b1;
      #1;
      model_reset();
      chk("areset.x",    32'(x),       32'd0);
      chk("areset.busy", 32'(busy),    32'd0);
      chk("areset.idx",  32'(bit_idx), 32'd0);
      #1 RESET = 1'b0;
      start(16'b1111_0111, 8, 0);
      step("ar_restart");
      idle_inputs();
      for (int i = 0; i < 9; i++) step("ar_rerun");

      // Pattern 1,1,1,1,0,0 repeating as a sequence-machine stimulus.
      start(16'b00_1111, 6, 1);
      step("jk_accept");
      idle_inputs();
      for (int i = 0; i < 14; i++) step("jk_run");
      stop = 1'b1;
      step("jk_stop");
      idle_inputs();

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         load      = ($urandom_range(0, 3) == 0);
         stop      = ($urandom_range(0, 15) == 0);
         pattern   = $urandom;
         length    = LEN_W'($urandom);
         repeat_en = 1'($urandom);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timed out");
   end

endmodule
